split_tracked: RTL and testbench
================================

Name: split_tracked

Overview:
- Registered successor to the plain combinational master-to-N-slave split on the native valid/ready bus.
- Routes one master request to the slave chosen by `s_sel`.
- Tracks outstanding transactions so that late, multi-cycle slave responses return to the master from the correct slave.
- Out-of-range selects are answered by an internal error responder.
- Sits between a CPU/DMA master port and peripheral or memory slaves.

Parameters:
- N_SLAVES, 2: number of slave ports; must be >= 2.
- SEL_W, $clog2(N_SLAVES): width of `s_sel`; may exceed minimum so that encodings >= N_SLAVES exist.
- ADDR_W, 32: request address width.
- DATA_W, 32: data width; STRB_W = DATA_W/8.
- MAX_OUT, 4: maximum outstanding requests; must be >= 1.
- ERR_DATA, 32'hDEADBEEF: rdata returned for out-of-range selects.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  REQ_W  master request {valid(MSB), addr, wdata, wstrb}; REQ_W = 1+ADDR_W+DATA_W+STRB_W.
- m_busy  out  1  split cannot accept; master must hold m_req stable while busy.
- m_resp  out  RESP_W  master response {rdata, ready(LSB)}; RESP_W = DATA_W+1.
- s_sel  in  SEL_W  target slave index, valid with m_req.
- s_req  out  N_SLAVES*REQ_W  slave requests; slave i occupies bits [i*REQ_W +: REQ_W].
- s_resp  in  N_SLAVES*RESP_W  slave responses; slave i occupies bits [i*RESP_W +: RESP_W].
- stray  out  1  one-cycle pulse: a ready arrived that matched no outstanding request.

Behaviour:
- State: `cnt` (0..MAX_OUT, width $clog2(MAX_OUT+1)), `cur_sel` (SEL_W), `err_rdy` (1).
  - Reset: cnt=0, cur_sel=0, err_rdy=0, stray=0.
  - Mid-operation reset discards all outstanding transactions.
- m_busy:
  - Depends on registered state and `s_sel` only, never on `s_resp`.
  - m_busy = (cnt==MAX_OUT) | (cnt!=0 & s_sel!=cur_sel).
  - Effect: no two slaves ever hold outstanding requests at once, so responses stay in order.
- Accept: acc = m_valid & ~m_busy.
- s_req:
  - addr, wdata and wstrb are broadcast combinationally to all slaves.
  - Valid bit of slave i = acc & (s_sel==i); all other valid bits are 0.
  - An out-of-range s_sel drives no slave valid.
- On acc:
  - cur_sel <= s_sel.
  - If s_sel >= N_SLAVES, err_rdy <= 1 for exactly the next cycle.
- Response source:
  - rsp_rdy = (cur_sel < N_SLAVES) ? ready of s_resp[cur_sel] : err_rdy.
  - Valid response vld = rsp_rdy & (cnt!=0).
  - Minimum latency, accept to response, is 1 cycle. A ready in the accept cycle with cnt==0 is stray.
- m_resp:
  - ready = vld.
  - rdata = slave cur_sel rdata, or ERR_DATA for the error path; rdata is forced to 0 when vld=0.
- cnt update:
  - +1 on acc only.
  - −1 on vld only.
  - Unchanged on simultaneous acc and vld.
  - Never wraps: acc is impossible at MAX_OUT, vld is impossible at 0.
- stray:
  - Registered; set next cycle if any slave j asserted ready with (cnt==0 | j!=cur_sel), else 0.
  - Stray responses are never forwarded to the master.
- Full boundary: at cnt==MAX_OUT a same-cycle response does not unblock acceptance. Acceptance resumes the cycle after cnt drops.
- Slaves are required to answer in order, one ready per accepted request.

Decomposition:
- Shared include/package for the interconnect:
  - REQ_W and RESP_W derivation.
  - Field-slice macros for valid/addr/wdata/wstrb and rdata/ready.
  - Per-port slice macros req(i) and resp(i).
- One sub-module, `split_track`:
  - Holds cnt, cur_sel and err_rdy.
  - Outputs busy and vld.
  - Reused later by the multi-master merge.
- The top level holds s_req valid gating, the response mux and stray detection.

Test Plan:
- Single read: N=2, s_sel=1, valid pulse, slave1 ready 3 cycles later with rdata=0x1234 → m_resp=0x1234 with ready for 1 cycle; cnt returns to 0; slave0 never sees valid.
- Back-to-back, MAX_OUT=4: 4 accepts to slave0 with no response → m_busy=1 on the 5th cycle. One response returns → m_busy=0 on the following cycle, not the same cycle.
- Select switch: 2 outstanding on slave0, new request with s_sel=1 → m_busy=1 until both slave0 responses return, then accepted the next cycle.
- Error path: N=3, SEL_W=2, s_sel=3 → no slave valid; m_resp ready exactly 1 cycle later with rdata=0xDEADBEEF.
- Stray response: cnt=0, slave1 asserts ready → m_resp.ready=0, stray=1 for one cycle.
- Reset mid-flight: 3 outstanding, rst=1 for 1 cycle → cnt=0, m_busy=0; a late slave ready afterwards pulses stray and is not forwarded.

Source files
------------

// File: rtl/split_tracked_pkg.sv
// Shared definitions for the tracked master-to-N-slave split and its bookkeeping.
// This package derives the packed bus widths and names the source of the response.
package split_tracked_pkg;

    typedef enum logic {
        RSP_SLAVE = 1'b0,
        RSP_ERROR = 1'b1
    } rsp_src_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // Request layout is {valid, addr, wdata, wstrb}, with valid in the MSB.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response layout is {rdata, ready}, with ready in the LSB.
    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/split_tracked_if.sv
// Bundles the master-facing and slave-facing buses of split_tracked.
// The slave modport is the view the split itself takes; the master modport is its environment.
interface split_tracked_if #(
    parameter int N_SLAVES = 2,
    parameter int SEL_W    = $clog2(N_SLAVES),
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    import split_tracked_pkg::*;

    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);

    logic [REQ_W-1:0]           m_req;
    logic                       m_busy;
    logic [RESP_W-1:0]          m_resp;
    logic [SEL_W-1:0]           s_sel;
    logic [N_SLAVES*REQ_W-1:0]  s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp;
    logic                       stray;

    modport slave (
        input  m_req,
        input  s_sel,
        input  s_resp,
        output m_busy,
        output m_resp,
        output s_req,
        output stray
    );

    modport master (
        output m_req,
        output s_sel,
        output s_resp,
        input  m_busy,
        input  m_resp,
        input  s_req,
        input  stray
    );

endinterface

// File: rtl/split_track.sv
// Outstanding-transaction tracker: counts accepted requests, remembers the target slave
// and generates the one-shot ready used for selects that no slave decodes.
module split_track
    import split_tracked_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int SEL_W    = $clog2(N_SLAVES),
    parameter int MAX_OUT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_valid,
    input  logic [SEL_W-1:0]    s_sel,
    input  logic [N_SLAVES-1:0] rdy_vec,
    output logic                busy,
    output logic                acc,
    output logic                vld,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                cnt_zero,
    output rsp_src_e            src
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0]        cnt;
    logic                    err_rdy;
    logic                    rsp_rdy;
    logic [(1<<SEL_W)-1:0]   rdy_pad;

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return int'(sel) < N_SLAVES;
    endfunction

    // Busy never looks at the responses, so a response at the full limit cannot reopen the port in the same cycle.
    assign busy     = (cnt == CNT_W'(MAX_OUT)) | ((cnt != '0) & (s_sel != cur_sel));
    assign acc      = m_valid & ~busy;
    assign cnt_zero = (cnt == '0);
    assign src      = in_range(cur_sel) ? RSP_SLAVE : RSP_ERROR;

    always_comb begin
        rdy_pad                = '0;
        rdy_pad[N_SLAVES-1:0]  = rdy_vec;
    end

    assign rsp_rdy = (src == RSP_SLAVE) ? rdy_pad[cur_sel] : err_rdy;
    assign vld     = rsp_rdy & ~cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cur_sel <= '0;
            err_rdy <= 1'b0;
        end else begin
            err_rdy <= acc & ~in_range(s_sel);
            if (acc) begin
                cur_sel <= s_sel;
            end
            if (acc && !vld) begin
                cnt <= cnt + CNT_W'(1);
            end else if (vld && !acc) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/split_tracked.sv
// Registered master-to-N-slave split: gates request valids by select, steers responses back
// from the slave that owns the outstanding requests, and flags readies nobody asked for.
module split_tracked
    import split_tracked_pkg::*;
#(
    parameter int                 N_SLAVES = 2,
    parameter int                 SEL_W    = $clog2(N_SLAVES),
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 MAX_OUT  = 4,
    parameter logic [DATA_W-1:0]  ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic           clk,
    input  logic           rst,
    split_tracked_if.slave bus
);

    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);

    logic                m_valid;
    logic                busy;
    logic                acc;
    logic                vld;
    logic [SEL_W-1:0]    cur_sel;
    logic                cnt_zero;
    rsp_src_e            src;
    logic [N_SLAVES-1:0] rdy_vec;
    logic [N_SLAVES-1:0] stray_vec;
    logic [DATA_W-1:0]   sel_rdata;
    logic                stray_q;

    assign m_valid = bus.m_req[REQ_W-1];

    split_track #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W),
        .MAX_OUT  (MAX_OUT)
    ) u_track (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .s_sel    (bus.s_sel),
        .rdy_vec  (rdy_vec),
        .busy     (busy),
        .acc      (acc),
        .vld      (vld),
        .cur_sel  (cur_sel),
        .cnt_zero (cnt_zero),
        .src      (src)
    );

    // Payload fans out to every slave; only the selected slave sees valid.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_port
        assign bus.s_req[i*REQ_W +: REQ_W] = {acc & (bus.s_sel == SEL_W'(i)), bus.m_req[REQ_W-2:0]};
        assign rdy_vec[i]                  = bus.s_resp[i*RESP_W];
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                sel_rdata = bus.s_resp[i*RESP_W+1 +: DATA_W];
            end
        end
        if (src == RSP_ERROR) begin
            sel_rdata = ERR_DATA;
        end
    end

    assign bus.m_busy = busy;
    assign bus.m_resp = {(vld ? sel_rdata : {DATA_W{1'b0}}), vld};

    // A ready is stray when nothing is outstanding or it comes from a slave other than the owner.
    always_comb begin
        stray_vec = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            stray_vec[j] = rdy_vec[j] & (cnt_zero | (cur_sel != SEL_W'(j)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stray_q <= 1'b0;
        end else begin
            stray_q <= |stray_vec;
        end
    end

    assign bus.stray = stray_q;

endmodule

// File: tb/tb_split_tracked.sv
// Directed bench for split_tracked: a 2-slave instance for routing and tracking,
// and a 3-slave instance with a 2-bit select for the error responder.
module tb_split_tracked;

    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    split_tracked_if #(.N_SLAVES(2), .SEL_W(1), .ADDR_W(32), .DATA_W(32)) bus2 ();
    split_tracked_if #(.N_SLAVES(3), .SEL_W(2), .ADDR_W(32), .DATA_W(32)) bus3 ();

    split_tracked #(
        .N_SLAVES (2),
        .SEL_W    (1),
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_OUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    split_tracked #(
        .N_SLAVES (3),
        .SEL_W    (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_OUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic sel, input logic [31:0] addr);
        bus2.m_req = {v, addr, addr ^ 32'h0000FFFF, 4'hF};
        bus2.s_sel = sel;
    endtask

    task automatic setSlave(input int idx, input logic rdy, input logic [31:0] rdata);
        bus2.s_resp[idx*RESP_W +: RESP_W] = {rdata, rdy};
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total = total + 1;
        assert (observed === expected) passed = passed + 1;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        bus2.m_req  = '0;
        bus2.s_sel  = '0;
        bus2.s_resp = '0;
        bus3.m_req  = '0;
        bus3.s_sel  = '0;
        bus3.s_resp = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_busy", 64'(bus2.m_busy), 64'd0);
        checkOutput("reset_resp", 64'(bus2.m_resp), 64'd0);
        checkOutput("reset_stray", 64'(bus2.stray), 64'd0);
        tick();

        // Single read to slave 1, answered three cycles after acceptance.
        applyStimulus(1'b1, 1'b1, 32'h0000_0100);
        #1;
        checkOutput("rd_s1_valid", 64'(bus2.s_req[2*REQ_W-1]), 64'd1);
        checkOutput("rd_s0_valid", 64'(bus2.s_req[REQ_W-1]), 64'd0);
        checkOutput("rd_busy", 64'(bus2.m_busy), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0);
        tick();
        tick();
        setSlave(1, 1'b1, 32'h0000_1234);
        #1;
        checkOutput("rd_resp", 64'(bus2.m_resp), 64'({32'h0000_1234, 1'b1}));
        tick();
        setSlave(1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rd_resp_done", 64'(bus2.m_resp), 64'd0);
        checkOutput("rd_cnt_zero", 64'(bus2.m_busy), 64'd0);
        checkOutput("rd_no_stray", 64'(bus2.stray), 64'd0);

        // Four back-to-back accepts to slave 0 fill the tracker.
        applyStimulus(1'b1, 1'b0, 32'h0000_0200);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("b2b_accept", 64'(bus2.s_req[REQ_W-1]), 64'd1);
            tick();
        end
        #1;
        checkOutput("b2b_full_busy", 64'(bus2.m_busy), 64'd1);
        checkOutput("b2b_full_novalid", 64'(bus2.s_req[REQ_W-1]), 64'd0);
        setSlave(0, 1'b1, 32'h0000_00A0);
        #1;
        checkOutput("b2b_same_cycle_busy", 64'(bus2.m_busy), 64'd1);
        checkOutput("b2b_resp0", 64'(bus2.m_resp), 64'({32'h0000_00A0, 1'b1}));
        tick();
        setSlave(0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("b2b_next_cycle_free", 64'(bus2.m_busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            setSlave(0, 1'b1, 32'h0000_00B0 + 32'(k));
            #1;
            checkOutput("b2b_drain", 64'(bus2.m_resp), {31'd0, 32'h0000_00B0 + 32'(k), 1'b1});
            tick();
        end
        setSlave(0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        #1;
        checkOutput("b2b_drained", 64'(bus2.m_busy), 64'd0);

        // Switching slaves waits until the old slave has answered everything.
        applyStimulus(1'b1, 1'b0, 32'h0000_0300);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 32'h0000_0400);
        #1;
        checkOutput("sw_busy", 64'(bus2.m_busy), 64'd1);
        checkOutput("sw_s1_blocked", 64'(bus2.s_req[2*REQ_W-1]), 64'd0);
        tick();
        setSlave(0, 1'b1, 32'h0000_00C0);
        #1;
        checkOutput("sw_busy_2left", 64'(bus2.m_busy), 64'd1);
        checkOutput("sw_resp_c0", 64'(bus2.m_resp), 64'({32'h0000_00C0, 1'b1}));
        tick();
        setSlave(0, 1'b1, 32'h0000_00C1);
        #1;
        checkOutput("sw_busy_1left", 64'(bus2.m_busy), 64'd1);
        checkOutput("sw_resp_c1", 64'(bus2.m_resp), 64'({32'h0000_00C1, 1'b1}));
        tick();
        setSlave(0, 1'b0, 32'h0);
        #1;
        checkOutput("sw_free", 64'(bus2.m_busy), 64'd0);
        checkOutput("sw_s1_valid", 64'(bus2.s_req[2*REQ_W-1]), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0);
        setSlave(1, 1'b1, 32'h0000_00D0);
        #1;
        checkOutput("sw_resp_d0", 64'(bus2.m_resp), 64'({32'h0000_00D0, 1'b1}));
        tick();
        setSlave(1, 1'b0, 32'h0);

        // Ready with nothing outstanding is flagged and not forwarded.
        setSlave(1, 1'b1, 32'h0000_0055);
        #1;
        checkOutput("stray_not_fwd", 64'(bus2.m_resp), 64'd0);
        tick();
        setSlave(1, 1'b0, 32'h0);
        #1;
        checkOutput("stray_pulse", 64'(bus2.stray), 64'd1);
        tick();
        checkOutput("stray_one_cycle", 64'(bus2.stray), 64'd0);

        // Reset with three requests in flight forgets them.
        applyStimulus(1'b1, 1'b0, 32'h0000_0500);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(bus2.m_busy), 64'd0);
        setSlave(0, 1'b1, 32'h0000_00E0);
        #1;
        checkOutput("rst_late_not_fwd", 64'(bus2.m_resp), 64'd0);
        tick();
        setSlave(0, 1'b0, 32'h0);
        #1;
        checkOutput("rst_late_stray", 64'(bus2.stray), 64'd1);

        // Out-of-range select on the 3-slave instance goes to the error responder.
        bus3.m_req = {1'b1, 32'h0000_0600, 32'h0000_F9FF, 4'hF};
        bus3.s_sel = 2'd2;
        #1;
        checkOutput("err_inrange_valids",
                    64'({bus3.s_req[3*REQ_W-1], bus3.s_req[2*REQ_W-1], bus3.s_req[REQ_W-1]}), 64'b100);
        bus3.s_sel = 2'd3;
        #1;
        checkOutput("err_no_valids",
                    64'({bus3.s_req[3*REQ_W-1], bus3.s_req[2*REQ_W-1], bus3.s_req[REQ_W-1]}), 64'd0);
        checkOutput("err_busy", 64'(bus3.m_busy), 64'd0);
        tick();
        bus3.m_req = '0;
        #1;
        checkOutput("err_resp", 64'(bus3.m_resp), 64'({32'hDEADBEEF, 1'b1}));
        tick();
        checkOutput("err_resp_once", 64'(bus3.m_resp), 64'd0);
        checkOutput("err_no_stray", 64'(bus3.stray), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
